// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter and sequencer that shares one binary-to-BCD converter
// among NREQ requesters and returns tagged results on one response channel.
module bcd_conv_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned TIMEOUT = WIDTH + 8
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ*WIDTH-1:0]     req_data_i,
    output logic [NREQ-1:0]           req_ready_o,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [$clog2(NREQ)-1:0]   resp_id_o,
    output logic [4*DIGITS-1:0]       resp_bcd_o,
    output logic                      resp_err_o,
    output logic                      conv_start_o,
    output logic [WIDTH-1:0]          conv_data_o,
    input  logic                      conv_done_i,
    input  logic [4*DIGITS-1:0]       conv_bcd_i
);

    localparam int unsigned IDW  = $clog2(NREQ);
    localparam int unsigned BCDW = 4 * DIGITS;
    localparam int unsigned TOW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [TOW-1:0]   cnt_q, cnt_d;
    logic [BCDW-1:0]  bcd_q, bcd_d;
    logic             err_q, err_d;
    logic             start_q, rvalid_q;
    logic             grant_any;
    logic [IDW-1:0]   grant_idx;
    logic [NREQ-1:0]  grant_oh;

    // Requester index base+off reduced modulo NREQ (off < NREQ).
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                                input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // First valid requester searching upward from rr_ptr with wrap.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!grant_any && req_valid_i[wrap_idx(rr_ptr_q, k)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_idx(rr_ptr_q, k);
            end
        end
    end

    // Next-state logic plus the combinational grant.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        err_d    = err_q;
        grant_oh = '0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    grant_oh = NREQ'(1) << grant_idx;
                    opnd_d   = req_data_i[32'(grant_idx) * WIDTH +: WIDTH];
                    id_d     = grant_idx;
                    rr_ptr_d = wrap_idx(grant_idx, 1);
                    cnt_d    = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + TOW'(1);
                // done has priority over an expiring timeout
                if (conv_done_i) begin
                    bcd_d   = conv_bcd_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == TOW'(TIMEOUT - 1)) begin
                    bcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            err_q    <= err_d;
            start_q  <= (state_d == S_ISSUE);
            rvalid_q <= (state_d == S_RESP);
        end
    end

    // Grant is forced low while reset is held.
    assign req_ready_o  = reset_ni ? grant_oh : '0;
    assign resp_valid_o = rvalid_q;
    assign resp_id_o    = id_q;
    assign resp_bcd_o   = bcd_q;
    assign resp_err_o   = err_q;
    assign conv_start_o = start_q;
    assign conv_data_o  = opnd_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a behavioural converter model and
// a response scoreboard.
module tb_bcd_conv_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned TIMEOUT = 24;

    logic                    clk_i = 1'b0;
    logic                    reset_ni;
    logic [NREQ-1:0]         req_valid_i;
    logic [NREQ*WIDTH-1:0]   req_data_i;
    logic [NREQ-1:0]         req_ready_o;
    logic                    resp_valid_o;
    logic                    resp_ready_i;
    logic [1:0]              resp_id_o;
    logic [4*DIGITS-1:0]     resp_bcd_o;
    logic                    resp_err_o;
    logic                    conv_start_o;
    logic [WIDTH-1:0]        conv_data_o;
    logic                    conv_done_i;
    logic [4*DIGITS-1:0]     conv_bcd_i;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] bcd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   nvec  = 0;
    int   nfail = 0;
    int   lat;
    logic hang  = 1'b0;

    bcd_conv_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .DIGITS(DIGITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
        .resp_bcd_o(resp_bcd_o), .resp_err_o(resp_err_o),
        .conv_start_o(conv_start_o), .conv_data_o(conv_data_o),
        .conv_done_i(conv_done_i), .conv_bcd_i(conv_bcd_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Converter model: 4-digit decimal truncation.
    function automatic logic [15:0] to_bcd(input logic [15:0] v);
        logic [15:0] r;
        int unsigned x;
        x = 32'(v);
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Level start/done converter: load, WIDTH busy cycles, DONE until start drops.
    localparam logic [1:0] C_IDLE = 2'd0, C_RUN = 2'd1, C_DONE = 2'd2;
    logic [1:0]  cst;
    logic [4:0]  ccnt;
    logic [15:0] cdat;
    always @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cst  <= C_IDLE;
            ccnt <= '0;
            cdat <= '0;
        end else begin
            case (cst)
                C_IDLE: if (conv_start_o && !hang) begin
                    cst  <= C_RUN;
                    cdat <= conv_data_o;
                    ccnt <= '0;
                end
                C_RUN: if (ccnt == 5'(WIDTH - 1)) cst <= C_DONE; else ccnt <= ccnt + 5'd1;
                C_DONE: if (!conv_start_o) cst <= C_IDLE;
                default: cst <= C_IDLE;
            endcase
        end
    end
    assign conv_done_i = (cst == C_DONE);
    assign conv_bcd_i  = conv_done_i ? to_bcd(cdat) : 16'hDEAD;

    // Response monitor: compare each accepted response with the scoreboard head.
    always @(negedge clk_i) begin
        if (reset_ni && resp_valid_o && resp_ready_i) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("resp_id",  32'(resp_id_o),  32'(mon_e.id));
                check("resp_bcd", 32'(resp_bcd_o), 32'(mon_e.bcd));
                check("resp_err", 32'(resp_err_o), 32'(mon_e.err));
            end
        end
    end

    task automatic set_req(input int id, input logic [15:0] d);
        req_valid_i[id] = 1'b1;
        req_data_i[id*16 +: 16] = d;
    endtask

    // Wait for a grant, check it targets id; return cycles waited (1 = same cycle).
    task automatic wait_grant(input int id, input bit drop, output int l);
        l = 0;
        do begin
            @(negedge clk_i);
            l++;
        end while (req_ready_o == '0 && l < 400);
        check($sformatf("grant_id%0d", id), 32'(req_ready_o), 32'(1) << id);
        @(posedge clk_i);
        #1;
        if (drop) req_valid_i[id] = 1'b0;
    endtask

    task automatic wait_resp(input int l0, output int l);
        l = l0;
        while (!resp_valid_o && l < 400) begin
            @(negedge clk_i);
            l++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk_i);
        check("sb_drain", 32'(sb.size()), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_ni     = 1'b0;
        req_valid_i  = '0;
        req_data_i   = '0;
        resp_ready_i = 1'b1;
        #23;
        check("rst_ready",  32'(req_ready_o),  32'd0);
        check("rst_rvalid", 32'(resp_valid_o), 32'd0);
        check("rst_start",  32'(conv_start_o), 32'd0);
        check("rst_data",   32'(conv_data_o),  32'd0);
        check("rst_id",     32'(resp_id_o),    32'd0);
        check("rst_bcd",    32'(resp_bcd_o),   32'd0);
        check("rst_err",    32'(resp_err_o),   32'd0);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single request from id 2, then id 3 right behind it.
        set_req(2, 16'd1234);
        sb.push_back('{2'd2, 16'h1234, 1'b0});
        wait_grant(2, 1'b1, lat);
        check("single_grant_lat", 32'(lat), 32'd1);
        @(negedge clk_i);
        check("issue_start", 32'(conv_start_o), 32'd1);
        check("issue_data",  32'(conv_data_o),  32'd1234);
        wait_resp(1, lat);
        check("single_resp_lat", 32'(lat), 32'd19);
        @(posedge clk_i);
        #1;
        set_req(3, 16'd4321);
        sb.push_back('{2'd3, 16'h4321, 1'b0});
        wait_grant(3, 1'b1, lat);
        check("next_grant_lat", 32'(lat), 32'd1);
        drain();

        // Round robin with all four requesters held valid.
        set_req(0, 16'd0);
        set_req(1, 16'd9);
        set_req(2, 16'd65535);
        set_req(3, 16'd4999);
        sb.push_back('{2'd0, 16'h0000, 1'b0});
        sb.push_back('{2'd1, 16'h0009, 1'b0});
        sb.push_back('{2'd2, 16'h5535, 1'b0});
        sb.push_back('{2'd3, 16'h4999, 1'b0});
        sb.push_back('{2'd0, 16'h0000, 1'b0});
        wait_grant(0, 1'b0, lat);
        wait_grant(1, 1'b0, lat);
        check("rr_spacing1", 32'(lat), 32'd20);
        wait_grant(2, 1'b0, lat);
        check("rr_spacing2", 32'(lat), 32'd20);
        wait_grant(3, 1'b0, lat);
        check("rr_spacing3", 32'(lat), 32'd20);
        wait_grant(0, 1'b0, lat);
        req_valid_i = '0;
        drain();

        // Wrap-around: after serving id 3, id 0 wins over id 3.
        set_req(3, 16'd33);
        sb.push_back('{2'd3, 16'h0033, 1'b0});
        wait_grant(3, 1'b1, lat);
        drain();
        set_req(0, 16'd100);
        set_req(3, 16'd303);
        sb.push_back('{2'd0, 16'h0100, 1'b0});
        sb.push_back('{2'd3, 16'h0303, 1'b0});
        wait_grant(0, 1'b1, lat);
        wait_grant(3, 1'b1, lat);
        drain();

        // Backpressure: response held for 10 cycles with id 2 waiting.
        resp_ready_i = 1'b0;
        set_req(1, 16'd7);
        set_req(2, 16'd8);
        sb.push_back('{2'd1, 16'h0007, 1'b0});
        sb.push_back('{2'd2, 16'h0008, 1'b0});
        wait_grant(1, 1'b1, lat);
        wait_resp(0, lat);
        check("bp_resp_lat", 32'(lat), 32'd19);
        for (int i = 0; i < 10; i++) begin
            check("bp_rvalid", 32'(resp_valid_o), 32'd1);
            check("bp_id",     32'(resp_id_o),    32'd1);
            check("bp_bcd",    32'(resp_bcd_o),   32'h0007);
            check("bp_err",    32'(resp_err_o),   32'd0);
            check("bp_ready",  32'(req_ready_o),  32'd0);
            check("bp_start",  32'(conv_start_o), 32'd0);
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        resp_ready_i = 1'b1;
        wait_grant(2, 1'b1, lat);
        drain();

        // Timeout with a stuck converter, then a normal conversion.
        hang = 1'b1;
        set_req(3, 16'd555);
        sb.push_back('{2'd3, 16'h0000, 1'b1});
        wait_grant(3, 1'b1, lat);
        wait_resp(0, lat);
        check("to_resp_lat", 32'(lat), 32'(TIMEOUT + 1));
        check("to_err", 32'(resp_err_o), 32'd1);
        check("to_bcd", 32'(resp_bcd_o), 32'd0);
        drain();
        hang = 1'b0;
        set_req(0, 16'd9876);
        sb.push_back('{2'd0, 16'h9876, 1'b0});
        wait_grant(0, 1'b1, lat);
        wait_resp(0, lat);
        check("post_to_lat", 32'(lat), 32'd19);
        drain();

        // Reset in the middle of ISSUE.
        set_req(2, 16'd100);
        sb.push_back('{2'd2, 16'h0100, 1'b0});
        wait_grant(2, 1'b1, lat);
        repeat (5) @(posedge clk_i);
        #1;
        check("pre_rst_start", 32'(conv_start_o), 32'd1);
        reset_ni = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_start",  32'(conv_start_o), 32'd0);
        check("mid_rst_data",   32'(conv_data_o),  32'd0);
        check("mid_rst_rvalid", 32'(resp_valid_o), 32'd0);
        check("mid_rst_id",     32'(resp_id_o),    32'd0);
        check("mid_rst_ready",  32'(req_ready_o),  32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
        set_req(1, 16'd77);
        set_req(3, 16'd3);
        sb.push_back('{2'd1, 16'h0077, 1'b0});
        sb.push_back('{2'd3, 16'h0003, 1'b0});
        wait_grant(1, 1'b1, lat);
        check("post_rst_grant_lat", 32'(lat), 32'd1);
        wait_grant(3, 1'b1, lat);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
